// File: rtl/sdcard_clock_monitor.sv
// SD clock monitor: measures high/low half-periods of sd_clk_i in PCLK_i cycles
// and checks them against the programmed divider. Option: SDCARD_CLKMON_SYNC_EN.
module sdcard_clock_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TOL        = 1,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned MAX_HALVES = 32
) (
  input  logic             PCLK_i,
  input  logic             PRESET_i,
  input  logic             sd_clk_i,
  input  logic             mon_enable,
  input  logic             meas_start,
  input  logic [CNT_W-1:0] expected_divider,
  input  logic [CNT_W-1:0] stuck_limit,
  output logic             meas_busy,
  output logic             meas_done,
  output logic             freq_ok,
  output logic             clk_stuck,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low,
  output logic [7:0]       meas_halves
);

  localparam int unsigned TGT_W   = CNT_W + 1;
  localparam int unsigned MATCH_W = $clog2(STABLE_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE,
    ST_STUCK
  } state_t;

  state_t state_q, state_d;

  logic               sd_s;
  logic               sd_prev;
  logic               sd_edge;
  logic               sd_rise;
  logic [CNT_W-1:0]   half_cnt, half_cnt_d;
  logic [TGT_W-1:0]   target_q, target_d;
  logic [MATCH_W-1:0] match_cnt, match_d, match_nxt;
  logic [TGT_W-1:0]   cap_ext, dev;
  logic [CNT_W-1:0]   eff_limit;
  logic [7:0]         halves_nxt;
  logic               in_tol, stuck_hit, pass_hit, limit_hit, accept;
  logic               busy_d, done_d, freq_d, stuck_d;
  logic [CNT_W-1:0]   high_d, low_d;
  logic [7:0]         halves_d;

`ifdef SDCARD_CLKMON_SYNC_EN
  // Two-flop synchronizer for an asynchronous SD clock
  logic [1:0] sd_sync;
  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) sd_sync <= 2'b00;
    else          sd_sync <= {sd_sync[0], sd_clk_i};
  end
  assign sd_s = sd_sync[1];
`else
  assign sd_s = sd_clk_i;
`endif

  assign sd_edge = sd_s ^ sd_prev;
  assign sd_rise = sd_s & ~sd_prev;

  // Tolerance check at CNT_W+1 bits so neither the target nor the difference wraps
  assign cap_ext    = TGT_W'(half_cnt);
  assign dev        = (cap_ext >= target_q) ? (cap_ext - target_q) : (target_q - cap_ext);
  assign in_tol     = (dev <= TGT_W'(TOL));
  assign eff_limit  = (stuck_limit == '0) ? CNT_W'(1) : stuck_limit;
  assign stuck_hit  = (half_cnt >= eff_limit);
  assign match_nxt  = in_tol ? (match_cnt + MATCH_W'(1)) : '0;
  assign pass_hit   = (match_nxt >= MATCH_W'(STABLE_CNT));
  assign halves_nxt = meas_halves + 8'd1;
  assign limit_hit  = (halves_nxt >= 8'(MAX_HALVES));

  // State register
  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; an edge takes precedence over the stuck limit
  always_comb begin
    state_d = state_q;
    if (!mon_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (meas_start) state_d = ST_ARM;
        ST_ARM: begin
          if (sd_edge)        state_d = ST_MEASURE;
          else if (stuck_hit) state_d = ST_STUCK;
        end
        ST_MEASURE: begin
          if (sd_edge) begin
            if (pass_hit || limit_hit) state_d = ST_DONE;
          end else if (stuck_hit) begin
            state_d = ST_STUCK;
          end
        end
        ST_DONE:    state_d = ST_IDLE;
        ST_STUCK:   state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    accept     = (state_q == ST_IDLE) && (state_d == ST_ARM);
    busy_d     = (state_d == ST_ARM) || (state_d == ST_MEASURE);
    done_d     = (state_d == ST_DONE) || (state_d == ST_STUCK);
    freq_d     = freq_ok;
    stuck_d    = clk_stuck;
    high_d     = meas_high;
    low_d      = meas_low;
    halves_d   = meas_halves;
    match_d    = match_cnt;
    target_d   = target_q;
    half_cnt_d = half_cnt;

    // Accepting a request restarts the counter as if an edge had just occurred
    if (sd_edge || accept)    half_cnt_d = CNT_W'(1);
    else if (half_cnt != '1)  half_cnt_d = half_cnt + CNT_W'(1);

    if (accept) begin
      target_d = TGT_W'(expected_divider) + TGT_W'(1);
      halves_d = 8'd0;
      match_d  = '0;
      stuck_d  = 1'b0;
      freq_d   = 1'b0;
    end

    if ((state_q == ST_MEASURE) && mon_enable && sd_edge) begin
      if (sd_rise) low_d  = half_cnt;
      else         high_d = half_cnt;
      halves_d = halves_nxt;
      match_d  = match_nxt;
      if (pass_hit) freq_d = 1'b1;
    end

    if (state_d == ST_STUCK) begin
      stuck_d = 1'b1;
      freq_d  = 1'b0;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      sd_prev     <= 1'b0;
      half_cnt    <= '0;
      target_q    <= '0;
      match_cnt   <= '0;
      meas_busy   <= 1'b0;
      meas_done   <= 1'b0;
      freq_ok     <= 1'b0;
      clk_stuck   <= 1'b0;
      meas_high   <= '0;
      meas_low    <= '0;
      meas_halves <= 8'd0;
    end else begin
      sd_prev     <= sd_s;
      half_cnt    <= half_cnt_d;
      target_q    <= target_d;
      match_cnt   <= match_d;
      meas_busy   <= busy_d;
      meas_done   <= done_d;
      freq_ok     <= freq_d;
      clk_stuck   <= stuck_d;
      meas_high   <= high_d;
      meas_low    <= low_d;
      meas_halves <= halves_d;
    end
  end

endmodule

// File: tb/tb_sdcard_clock_monitor.sv
// Directed bench for sdcard_clock_monitor: a programmable SD clock source with
// hand-computed expected lengths, outcomes and latencies.
module tb_sdcard_clock_monitor;

  localparam int unsigned CNT_W = 16;

  logic             PCLK_i = 1'b0;
  logic             PRESET_i;
  logic             sd_clk_i;
  logic             mon_enable;
  logic             meas_start;
  logic [CNT_W-1:0] expected_divider;
  logic [CNT_W-1:0] stuck_limit;
  logic             meas_busy;
  logic             meas_done;
  logic             freq_ok;
  logic             clk_stuck;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_low;
  logic [7:0]       meas_halves;

  int n_tests = 0;
  int n_fail  = 0;

  logic gen_on = 1'b0;
  int   hi_len = 4;
  int   lo_len = 4;

  sdcard_clock_monitor dut (
    .PCLK_i           (PCLK_i),
    .PRESET_i         (PRESET_i),
    .sd_clk_i         (sd_clk_i),
    .mon_enable       (mon_enable),
    .meas_start       (meas_start),
    .expected_divider (expected_divider),
    .stuck_limit      (stuck_limit),
    .meas_busy        (meas_busy),
    .meas_done        (meas_done),
    .freq_ok          (freq_ok),
    .clk_stuck        (clk_stuck),
    .meas_high        (meas_high),
    .meas_low         (meas_low),
    .meas_halves      (meas_halves)
  );

  initial forever #5 PCLK_i = ~PCLK_i;

  // SD clock source: each level is held for hi_len / lo_len PCLK cycles
  initial begin
    int ph_cnt;
    ph_cnt   = 0;
    sd_clk_i = 1'b0;
    forever begin
      @(negedge PCLK_i);
      if (!gen_on) begin
        sd_clk_i = 1'b0;
        ph_cnt   = 0;
      end else begin
        ph_cnt++;
        if (ph_cnt >= (sd_clk_i ? hi_len : lo_len)) begin
          sd_clk_i = ~sd_clk_i;
          ph_cnt   = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // meas_start is high for the cycle ending at the next posedge (cycle 0)
  task automatic start_meas();
    @(negedge PCLK_i);
    meas_start = 1'b1;
    @(negedge PCLK_i);
    meas_start = 1'b0;
  endtask

  // Returns the cycle index (meas_start cycle = 0) at which meas_done is seen
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!meas_done && cyc < budget) begin
      @(negedge PCLK_i);
      cyc++;
    end
    check("meas_done_seen", 32'(meas_done), 32'd1);
  endtask

  task automatic run_meas(input int div, input int hi, input int lo, input int limit);
    int cyc;
    expected_divider = CNT_W'(div);
    stuck_limit      = CNT_W'(limit);
    hi_len           = hi;
    lo_len           = lo;
    gen_on           = 1'b1;
    start_meas();
    wait_done(500, cyc);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge PCLK_i);
    check(tag, 32'(meas_done), 32'd0);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    PRESET_i         = 1'b1;
    mon_enable       = 1'b0;
    meas_start       = 1'b0;
    expected_divider = '0;
    stuck_limit      = '0;
    repeat (3) @(negedge PCLK_i);

    check("rst_busy",   32'(meas_busy),   32'd0);
    check("rst_done",   32'(meas_done),   32'd0);
    check("rst_freq",   32'(freq_ok),     32'd0);
    check("rst_stuck",  32'(clk_stuck),   32'd0);
    check("rst_high",   32'(meas_high),   32'd0);
    check("rst_low",    32'(meas_low),    32'd0);
    check("rst_halves", 32'(meas_halves), 32'd0);

    PRESET_i   = 1'b0;
    mon_enable = 1'b1;
    repeat (2) @(negedge PCLK_i);

    // Nominal: divider 3, 4 cycles per half
    run_meas(3, 4, 4, 100);
    check("t1_freq",   32'(freq_ok),     32'd1);
    check("t1_stuck",  32'(clk_stuck),   32'd0);
    check("t1_high",   32'(meas_high),   32'd4);
    check("t1_low",    32'(meas_low),    32'd4);
    check("t1_halves", 32'(meas_halves), 32'd4);
    check("t1_busy",   32'(meas_busy),   32'd0);
    check_pulse_end("t1_done_pulse");

    // Too slow: 6 per half, never in tolerance
    run_meas(3, 6, 6, 100);
    check("t2_freq",   32'(freq_ok),     32'd0);
    check("t2_high",   32'(meas_high),   32'd6);
    check("t2_low",    32'(meas_low),    32'd6);
    check("t2_halves", 32'(meas_halves), 32'd32);

    // Asymmetric 6/4: matches never run consecutively
    run_meas(3, 6, 4, 100);
    check("t3a_freq",   32'(freq_ok),     32'd0);
    check("t3a_high",   32'(meas_high),   32'd6);
    check("t3a_low",    32'(meas_low),    32'd4);
    check("t3a_halves", 32'(meas_halves), 32'd32);

    // 5 per half: off by exactly TOL, still passes
    run_meas(3, 5, 5, 100);
    check("t3b_freq",   32'(freq_ok),     32'd1);
    check("t3b_high",   32'(meas_high),   32'd5);
    check("t3b_halves", 32'(meas_halves), 32'd4);

    // Stuck clock at 0, limit 100: done 101 cycles after meas_start
    gen_on = 1'b0;
    repeat (10) @(negedge PCLK_i);
    expected_divider = CNT_W'(3);
    stuck_limit      = CNT_W'(100);
    start_meas();
    wait_done(300, cyc);
    check("t4_latency", 32'(cyc),         32'd101);
    check("t4_stuck",   32'(clk_stuck),   32'd1);
    check("t4_freq",    32'(freq_ok),     32'd0);
    check("t4_halves",  32'(meas_halves), 32'd0);
    check_pulse_end("t4_done_pulse");
    check("t4_stuck_held", 32'(clk_stuck), 32'd1);

    // Next accepted start clears clk_stuck
    hi_len = 4;
    lo_len = 4;
    gen_on = 1'b1;
    start_meas();
    check("t4_stuck_clr", 32'(clk_stuck), 32'd0);
    check("t4_busy",      32'(meas_busy), 32'd1);
    wait_done(500, cyc);
    check("t4_freq2",     32'(freq_ok),   32'd1);

    // stuck_limit of 0 behaves as 1
    gen_on = 1'b0;
    repeat (10) @(negedge PCLK_i);
    stuck_limit = '0;
    start_meas();
    wait_done(50, cyc);
    check("t4b_latency", 32'(cyc),       32'd2);
    check("t4b_stuck",   32'(clk_stuck), 32'd1);

    // Edge coincides with stuck limit: the edge wins
    run_meas(3, 4, 4, 4);
    check("tes_freq",  32'(freq_ok),   32'd1);
    check("tes_stuck", 32'(clk_stuck), 32'd0);

    // mon_enable dropped mid-measurement; meas_start while busy ignored
    expected_divider = CNT_W'(3);
    stuck_limit      = CNT_W'(100);
    hi_len           = 6;
    lo_len           = 6;
    gen_on           = 1'b1;
    start_meas();
    repeat (30) @(negedge PCLK_i);
    check("t5_busy", 32'(meas_busy), 32'd1);
    start_meas();
    check("t5_start_ignored", 32'(meas_halves != 8'd0), 32'd1);
    check("t5_busy_kept",     32'(meas_busy),           32'd1);
    mon_enable = 1'b0;
    @(negedge PCLK_i);
    check("t5_busy_off", 32'(meas_busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (meas_done) done_cnt++;
      @(negedge PCLK_i);
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);
    mon_enable = 1'b1;

    // Reset mid-measurement, then a divider-1 measurement
    hi_len = 4;
    lo_len = 4;
    start_meas();
    repeat (12) @(negedge PCLK_i);
    PRESET_i = 1'b1;
    @(negedge PCLK_i);
    PRESET_i = 1'b0;
    check("t6_busy",   32'(meas_busy),   32'd0);
    check("t6_done",   32'(meas_done),   32'd0);
    check("t6_freq",   32'(freq_ok),     32'd0);
    check("t6_high",   32'(meas_high),   32'd0);
    check("t6_low",    32'(meas_low),    32'd0);
    check("t6_halves", 32'(meas_halves), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK_i);
      if (meas_done) done_cnt++;
    end
    check("t6_no_done", 32'(done_cnt), 32'd0);
    run_meas(1, 2, 2, 100);
    check("t6_freq2",   32'(freq_ok),     32'd1);
    check("t6_high2",   32'(meas_high),   32'd2);
    check("t6_low2",    32'(meas_low),    32'd2);
    check("t6_halves2", 32'(meas_halves), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
